register_hazard_scoreboard: RTL and testbench



---
 rtl/register_hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_register_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/register_hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight destinations and derives issue stall and operand forward selects.
// Optional operand forwarding is enabled by defining HAZARD_FORWARDING_EN.
module register_hazard_scoreboard #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ADDR_WIDTH-1:0]  issue_src_a,
  input  logic [ADDR_WIDTH-1:0]  issue_src_b,
  input  logic [ADDR_WIDTH-1:0]  issue_dest,
  input  logic                   issue_writes,
  input  logic                   issue_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [2:0]             forward_select_a,
  output logic [2:0]             forward_select_b,
  output logic [COUNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned SEL_WIDTH = 3;

  logic [STAGES-1:0]     ent_valid;
  logic [STAGES-1:0]     ent_load;
  logic [ADDR_WIDTH-1:0] ent_dest [STAGES];

  logic                  hit_a;
  logic                  hit_b;
  logic [SEL_WIDTH-1:0]  idx_a;
  logic [SEL_WIDTH-1:0]  idx_b;
  logic                  load_use;
  logic                  stall_raw;
  logic                  enter_valid;

  // Youngest-match search: scan oldest to youngest so the lowest stage wins.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_dest[k] == issue_src_a) && (issue_src_a != '0)) begin
        hit_a = 1'b1;
        idx_a = SEL_WIDTH'(k);
      end
      if (ent_valid[k] && (ent_dest[k] == issue_src_b) && (issue_src_b != '0)) begin
        hit_b = 1'b1;
        idx_b = SEL_WIDTH'(k);
      end
    end
  end

  assign load_use = ent_load[0] &&
                    ((hit_a && (idx_a == '0)) || (hit_b && (idx_b == '0)));

`ifdef HAZARD_FORWARDING_EN
  assign stall_raw        = load_use;
  assign forward_select_a = (issue_valid && !stall && hit_a) ? idx_a + SEL_WIDTH'(1) : '0;
  assign forward_select_b = (issue_valid && !stall && hit_b) ? idx_b + SEL_WIDTH'(1) : '0;
`else
  // A load-use is always also a plain hit, so folding it in changes nothing.
  assign stall_raw        = hit_a | hit_b | load_use;
  assign forward_select_a = '0;
  assign forward_select_b = '0;
`endif

  assign stall       = issue_valid & stall_raw;
  assign enter_valid = issue_valid & ~stall & issue_writes & (issue_dest != '0);

  // Valid bits: cleared by reset or flush, otherwise shift with stage 0 taking the issue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      ent_valid <= '0;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        ent_valid[k] <= ent_valid[k-1];
      end
      ent_valid[0] <= enter_valid;
    end
  end

  // Payload shifts unconditionally; it is only meaningful under its valid bit.
  always_ff @(posedge clock) begin
    for (int k = STAGES - 1; k >= 1; k--) begin
      ent_dest[k] <= ent_dest[k-1];
      ent_load[k] <= ent_load[k-1];
    end
    ent_dest[0] <= issue_dest;
    ent_load[0] <= issue_is_load;
  end

  // Saturating stall-cycle counter, untouched by flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_register_hazard_scoreboard.sv
// Bench for register_hazard_scoreboard: directed plan steps plus random traffic against an age-indexed model.
module tb_register_hazard_scoreboard;
  localparam int unsigned AW = 5;
  localparam int unsigned ST = 3;
  localparam int unsigned CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_src_a = '0;
  logic [AW-1:0] issue_src_b = '0;
  logic [AW-1:0] issue_dest = '0;
  logic          issue_writes = 1'b0;
  logic          issue_is_load = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [2:0]    forward_select_a;
  logic [2:0]    forward_select_b;
  logic [CW-1:0] stall_cycles;

  register_hazard_scoreboard #(.ADDR_WIDTH(AW), .STAGES(ST), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_dest(issue_dest),
    .issue_writes(issue_writes), .issue_is_load(issue_is_load), .flush(flush),
    .stall(stall), .forward_select_a(forward_select_a), .forward_select_b(forward_select_b),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Model: in-flight writers indexed by age in cycles since issue (age 0 = issued last cycle).
  logic          m_valid [ST];
  logic [AW-1:0] m_dest  [ST];
  logic          m_load  [ST];
  longint        m_count;
  logic          e_stall;
  bit            checking = 1'b0;
  int            tests = 0;
  int            fails = 0;

  function automatic int youngest(input logic [AW-1:0] src);
    if (src == 0) return -1;
    for (int k = 0; k < ST; k++) if (m_valid[k] && m_dest[k] == src) return k;
    return -1;
  endfunction

  task automatic check_model(input string tag);
    int ka, kb;
    logic [2:0] efa, efb;
    ka = youngest(issue_src_a);
    kb = youngest(issue_src_b);
`ifdef HAZARD_FORWARDING_EN
    e_stall = issue_valid && ((ka == 0 && m_load[0]) || (kb == 0 && m_load[0]));
    efa = (issue_valid && !e_stall && ka >= 0) ? 3'(ka + 1) : 3'd0;
    efb = (issue_valid && !e_stall && kb >= 0) ? 3'(kb + 1) : 3'd0;
`else
    e_stall = issue_valid && (ka >= 0 || kb >= 0);
    efa = 3'd0;
    efb = 3'd0;
`endif
    if (checking) begin
      tests++;
      assert (stall === e_stall) else begin
        fails++; $error("FAIL %s stall got=%0b exp=%0b", tag, stall, e_stall);
      end
      tests++;
      assert (forward_select_a === efa) else begin
        fails++; $error("FAIL %s fwd_a got=%0d exp=%0d", tag, forward_select_a, efa);
      end
      tests++;
      assert (forward_select_b === efb) else begin
        fails++; $error("FAIL %s fwd_b got=%0d exp=%0d", tag, forward_select_b, efb);
      end
      tests++;
      assert (stall_cycles === CW'(m_count)) else begin
        fails++; $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, m_count);
      end
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present inputs just after an edge and check at mid-cycle.
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic w, input logic ld,
                       input logic fl, input string tag);
    issue_valid = v; issue_src_a = a; issue_src_b = b; issue_dest = d;
    issue_writes = w; issue_is_load = ld; flush = fl;
    #4;
    check_model(tag);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < ST; k++) m_valid[k] = 1'b0;
      m_count = 0;
    end else begin
      if (e_stall && m_count < (64'd1 << CW) - 1) m_count++;
      if (flush) begin
        for (int k = 0; k < ST; k++) m_valid[k] = 1'b0;
      end else begin
        for (int k = ST - 1; k >= 1; k--) begin
          m_valid[k] = m_valid[k-1]; m_dest[k] = m_dest[k-1]; m_load[k] = m_load[k-1];
        end
        m_valid[0] = issue_valid && !e_stall && issue_writes && issue_dest != 0;
        m_dest[0]  = issue_dest;
        m_load[0]  = issue_is_load;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, "rst");
    tick();
    reset = 1'b0;
    checking = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < ST; k++) begin
      m_valid[k] = 1'b0; m_dest[k] = '0; m_load[k] = 1'b0;
    end
    m_count = 0;
    e_stall = 1'b0;
    #1;
    do_reset();

    drive(0, 0, 0, 0, 0, 0, 0, "reset_state");
    expect_val("reset_stall", 32'(stall), 0);
    expect_val("reset_count", 32'(stall_cycles), 0);
    tick();

`ifdef HAZARD_FORWARDING_EN
    drive(1, 0, 0, 5, 1, 0, 0, "p1_issue"); tick();
    drive(1, 5, 0, 0, 0, 0, 0, "p1_use");
    expect_val("p1_stall", 32'(stall), 0);
    expect_val("p1_fwd_a", 32'(forward_select_a), 1);
    tick();
    drive(1, 0, 0, 8, 1, 1, 0, "p2_load"); tick();
    drive(1, 0, 8, 0, 0, 0, 0, "p2_use0");
    expect_val("p2_stall", 32'(stall), 1);
    tick();
    drive(1, 0, 8, 0, 0, 0, 0, "p2_use1");
    expect_val("p2_fwd_b", 32'(forward_select_b), 2);
    expect_val("p2_stall_after", 32'(stall), 0);
    expect_val("p2_count", 32'(stall_cycles), 1);
    tick();
    drive(1, 0, 0, 3, 1, 0, 0, "p3_i0"); tick();
    drive(1, 0, 0, 3, 1, 0, 0, "p3_i1"); tick();
    drive(1, 3, 0, 0, 0, 0, 0, "p3_use");
    expect_val("p3_fwd_a", 32'(forward_select_a), 1);
    tick();
`else
    drive(1, 0, 0, 7, 1, 0, 0, "p6_issue"); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 7, 0, 0, 0, 0, 0, "p6_use");
      expect_val("p6_stall", 32'(stall), (i <= 3) ? 1 : 0);
      expect_val("p6_fwd_a", 32'(forward_select_a), 0);
      tick();
    end
    expect_val("p6_count", 32'(stall_cycles), 3);
`endif
    drive(1, 0, 0, 0, 1, 0, 0, "p4_issue"); tick();
    drive(1, 0, 0, 0, 0, 0, 0, "p4_use");
    expect_val("p4_stall", 32'(stall), 0);
    expect_val("p4_fwd_a", 32'(forward_select_a), 0);
    expect_val("p4_fwd_b", 32'(forward_select_b), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, "drain0"); tick();
    drive(0, 0, 0, 0, 0, 0, 0, "drain1"); tick();
    drive(0, 0, 0, 0, 0, 0, 0, "drain2"); tick();
    drive(1, 0, 0, 9, 1, 0, 0, "p5_issue"); tick();
    drive(0, 0, 0, 0, 0, 0, 1, "p5_flush"); tick();
    drive(1, 9, 0, 0, 0, 0, 0, "p5_use");
    expect_val("p5_stall", 32'(stall), 0);
    expect_val("p5_fwd_a", 32'(forward_select_a), 0);
    tick();

    // Random traffic over a small register range so hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0, "rand");
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
